// File: rtl/bcd_conv_arbiter_if.sv
// Request/grant/result bundle between the two requesters and the shared
// binary-to-BCD converter.
interface bcd_conv_arbiter_if;
   logic        sum_req_i;
   logic [15:0] sum_hex_i;
   logic        n_req_i;
   logic [7:0]  n_hex_i;
   logic        sum_gnt_o;
   logic        n_gnt_o;
   logic        busy_o;
   logic [19:0] dec_o;
   logic [11:0] n_dec_o;
   logic        dec_valid_o;
   logic        n_dec_valid_o;

   modport slave (
      input  sum_req_i, sum_hex_i, n_req_i, n_hex_i,
      output sum_gnt_o, n_gnt_o, busy_o, dec_o, n_dec_o, dec_valid_o, n_dec_valid_o
   );

   modport master (
      output sum_req_i, sum_hex_i, n_req_i, n_hex_i,
      input  sum_gnt_o, n_gnt_o, busy_o, dec_o, n_dec_o, dec_valid_o, n_dec_valid_o
   );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// One iterative shift-add-3 binary-to-BCD engine shared round-robin between a
// 16-bit sum requester and an 8-bit count requester.
module bcd_conv_arbiter (
   input  logic               clk_i,
   input  logic               rst_i,
   bcd_conv_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      r_state;
   logic [15:0] r_bin;
   logic [19:0] r_bcd;
   logic [3:0]  r_cnt;
   logic        r_prio_n;   // count requester wins the next tie
   logic        r_srv_n;    // current conversion belongs to the count requester
   logic        r_busy;
   logic        r_sum_gnt;
   logic        r_n_gnt;
   logic        r_dec_vld;
   logic        r_ndec_vld;
   logic [19:0] r_dec;
   logic [11:0] r_ndec;

   logic        w_any_req;
   logic        w_pick_n;
   logic [19:0] w_adj;

   assign w_any_req = bus.sum_req_i | bus.n_req_i;
   assign w_pick_n  = bus.n_req_i & (~bus.sum_req_i | r_prio_n);

   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < 5; k++) begin
         if (r_bcd[4*k +: 4] >= 4'd5)
            w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_prio_n   <= 1'b0;
         r_srv_n    <= 1'b0;
         r_busy     <= 1'b0;
         r_sum_gnt  <= 1'b0;
         r_n_gnt    <= 1'b0;
         r_dec_vld  <= 1'b0;
         r_ndec_vld <= 1'b0;
         r_dec      <= '0;
         r_ndec     <= '0;
      end else begin
         r_sum_gnt  <= 1'b0;
         r_n_gnt    <= 1'b0;
         r_dec_vld  <= 1'b0;
         r_ndec_vld <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_srv_n   <= w_pick_n;
                  r_prio_n  <= ~w_pick_n;
                  r_bin     <= w_pick_n ? {8'd0, bus.n_hex_i} : bus.sum_hex_i;
                  r_bcd     <= '0;
                  r_cnt     <= '0;
                  r_sum_gnt <= ~w_pick_n;
                  r_n_gnt   <= w_pick_n;
                  r_busy    <= 1'b1;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               // adjust-then-shift; binary MSB moves into the BCD LSB
               r_bcd <= {w_adj[18:0], r_bin[15]};
               r_bin <= {r_bin[14:0], 1'b0};
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd15)
                  r_state <= DONE;
            end
            DONE: begin
               if (r_srv_n) begin
                  r_ndec     <= r_bcd[11:0];
                  r_ndec_vld <= 1'b1;
               end else begin
                  r_dec     <= r_bcd;
                  r_dec_vld <= 1'b1;
               end
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.sum_gnt_o     = r_sum_gnt;
   assign bus.n_gnt_o       = r_n_gnt;
   assign bus.busy_o        = r_busy;
   assign bus.dec_o         = r_dec;
   assign bus.n_dec_o       = r_ndec;
   assign bus.dec_valid_o   = r_dec_vld;
   assign bus.n_dec_valid_o = r_ndec_vld;
endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 SHALL use one clock, clk_i, and a synchronous active-high reset, rst_i; no other clock or reset.
REQ-002 SHALL have the following ports (name  direction  width  meaning):
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  synchronous reset, active-high
- sum_req_i  in  1  sum requester wants a conversion; level, held until granted
- sum_hex_i  in  16  binary sum operand
- n_req_i  in  1  count requester wants a conversion; level, held until granted
- n_hex_i  in  8  binary count operand
- sum_gnt_o  out  1  one-cycle pulse: sum request accepted, operand captured
- n_gnt_o  out  1  one-cycle pulse: count request accepted, operand captured
- busy_o  out  1  high while a conversion is in progress
- dec_o  out  20  sum result, 5 BCD digits; digit k at bits [4k+3:4k], k=0 is the units digit
- n_dec_o  out  12  count result, 3 BCD digits, same packing
- dec_valid_o  out  1  one-cycle pulse: dec_o updated
- n_dec_valid_o  out  1  one-cycle pulse: n_dec_o updated
REQ-003 SHALL have no parameters; widths are fixed as listed.

Function
REQ-004 SHALL share one iterative shift-add-3 binary-to-BCD engine between the two requesters.
REQ-005 SHALL implement FSM states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on an edge where any request is high.
- SHIFT -> DONE after exactly 16 shift edges.
- DONE -> IDLE on the next edge.
REQ-006 SHALL, on the accepting edge (IDLE with a request), capture the winner's operand into the engine, zero-extending n_hex_i to 16 bits, clear the BCD field and the iteration counter, and assert the winner's gnt_o for the following cycle only.
REQ-007 SHALL arbitrate round-robin: if only one request is high, that requester wins; if both are high, the requester not served last wins; the pointer updates on each acceptance.
REQ-008 SHALL perform one iteration per SHIFT edge: add 3 to every 4-bit BCD nibble whose value is >= 5, then shift the {BCD, binary} register left by one bit; a 4-bit counter tracks iterations 0..15.
REQ-009 SHALL, on the DONE edge, write all 5 digits to dec_o (sum served) or the low 3 digits to n_dec_o (count served), and assert the matching valid_o for the following cycle only.
REQ-010 SHALL leave the result register of the requester not served unchanged; each result holds until that requester's next completion.
REQ-011 SHALL have a latency of 17 edges from the accepting edge to the result-write edge; the next request is accepted no earlier than the edge after DONE (18 cycles per conversion).
REQ-012 SHALL drive busy_o high exactly when the state is not IDLE.
REQ-013 SHALL ignore request levels and operand changes while busy; operands are sampled only on the accepting edge.
REQ-014 SHALL treat a request still high in the first IDLE cycle after its grant as a new request; requesters drop req within the gnt_o cycle to avoid a repeat conversion.
REQ-015 SHALL never assert sum_gnt_o and n_gnt_o together, or dec_valid_o and n_dec_valid_o together.
REQ-016 SHALL convert correctly at the operand boundaries 0 and 0xFFFF (sum) and 0 and 0xFF (count).

Reset
REQ-017 SHALL, on an edge with rst_i high: enter IDLE; zero the engine, counter, dec_o and n_dec_o; deassert all gnt_o, valid_o and busy_o; set the round-robin pointer so the sum requester wins the first tie.
REQ-018 SHALL abort any conversion in progress on reset, producing no valid pulse and writing no result.
REQ-019 SHALL give rst_i priority over every other event in the same cycle.

Verification
REQ-020 Bench SHALL cover:
- Reset, then sum_req_i=1 with sum_hex_i=0xFFFF -> sum_gnt_o pulses one cycle; 17 edges later dec_valid_o pulses; dec_o=0x65535; n_dec_o stays 0x000.
- n_req_i=1 with n_hex_i=0xFF -> n_gnt_o pulses; n_dec_o=0x255; dec_o unchanged.
- Both requests held continuously after reset, sum_hex_i=1234, n_hex_i=56 -> grants alternate sum, n, sum; dec_o=0x01234; n_dec_o=0x056; no overlapping pulses.
- rst_i asserted during the 8th SHIFT cycle -> no valid pulse; busy_o=0 and dec_o=0 the cycle after reset.
- sum_hex_i=0 -> dec_o=0x00000; sum_hex_i=10000 -> dec_o=0x10000; n_hex_i=100 -> n_dec_o=0x100.
- sum_hex_i changed from 42 to 99 one cycle after the grant -> dec_o=0x00042.
